game_clock_countdown: RTL

//  Quarter game clock for the scoreboard; sits directly downstream of timer_module.

---
 rtl/game_clock_countdown.sv | 132 +++++++++++++
 1 files changed

// File: rtl/game_clock_countdown.sv
// Quarter game clock: counts MM:SS down in BCD from QTR_MIN:00 on each rising edge of
// the 1 Hz tick, with run/pause control, quarter tracking, and quarter-end / game-over flags.
module game_clock_countdown #(
  parameter int QTR_MIN  = 15,
  parameter int NUM_QTRS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       start_stop,
  input  logic       next_qtr,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic [2:0] quarter,
  output logic       running,
  output logic       qtr_end,
  output logic       game_over
);

  localparam logic [3:0] MT_INIT = 4'(QTR_MIN / 10);
  localparam logic [3:0] MO_INIT = 4'(QTR_MIN % 10);
  localparam logic [2:0] LAST_Q  = 3'(NUM_QTRS);

  typedef enum logic [1:0] {S_STOP, S_RUN, S_EXPIRED, S_FINAL} state_t;

  state_t     state_q, state_d;
  logic       tick_q;
  logic [3:0] mt_q, mo_q, st_q, so_q;
  logic [3:0] mt_d, mo_d, st_d, so_d;
  logic [2:0] quarter_q, quarter_d;
  logic       running_q, running_d;
  logic       qtr_end_q, qtr_end_d;
  logic       game_over_q, game_over_d;

  logic sec_pulse;
  logic at_one;
  logic expire;

  assign sec_pulse = tick & ~tick_q;
  // Expiry is decided on the pre-decrement value, so the digits never wrap below 00:00.
  assign at_one    = (mt_q == 4'd0) && (mo_q == 4'd0) && (st_q == 4'd0) && (so_q == 4'd1);
  assign expire    = (state_q == S_RUN) && sec_pulse && at_one;

  // State register and all datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_STOP;
      tick_q      <= 1'b0;
      mt_q        <= MT_INIT;
      mo_q        <= MO_INIT;
      st_q        <= 4'd0;
      so_q        <= 4'd0;
      quarter_q   <= 3'd1;
      running_q   <= 1'b0;
      qtr_end_q   <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      tick_q      <= tick;
      mt_q        <= mt_d;
      mo_q        <= mo_d;
      st_q        <= st_d;
      so_q        <= so_d;
      quarter_q   <= quarter_d;
      running_q   <= running_d;
      qtr_end_q   <= qtr_end_d;
      game_over_q <= game_over_d;
    end
  end

  // Next-state logic; expiry takes priority over a simultaneous start_stop
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_STOP:    if (start_stop) state_d = S_RUN;
      S_RUN: begin
        if (expire)          state_d = (quarter_q == LAST_Q) ? S_FINAL : S_EXPIRED;
        else if (start_stop) state_d = S_STOP;
      end
      S_EXPIRED: if (next_qtr) state_d = S_STOP;
      default:   state_d = S_FINAL;
    endcase
  end

  // Output / datapath logic: BCD borrow chain, quarter advance, registered flags
  always_comb begin
    mt_d        = mt_q;
    mo_d        = mo_q;
    st_d        = st_q;
    so_d        = so_q;
    quarter_d   = quarter_q;
    running_d   = (state_d == S_RUN);
    qtr_end_d   = expire;
    game_over_d = (state_d == S_FINAL);
    if ((state_q == S_RUN) && sec_pulse) begin
      if (so_q != 4'd0) begin
        so_d = so_q - 4'd1;
      end else begin
        so_d = 4'd9;
        if (st_q != 4'd0) begin
          st_d = st_q - 4'd1;
        end else begin
          st_d = 4'd5;
          if (mo_q != 4'd0) begin
            mo_d = mo_q - 4'd1;
          end else begin
            mo_d = 4'd9;
            mt_d = mt_q - 4'd1;
          end
        end
      end
    end else if ((state_q == S_EXPIRED) && next_qtr) begin
      mt_d      = MT_INIT;
      mo_d      = MO_INIT;
      st_d      = 4'd0;
      so_d      = 4'd0;
      quarter_d = quarter_q + 3'd1;
    end
  end

  assign min_tens  = mt_q;
  assign min_ones  = mo_q;
  assign sec_tens  = st_q;
  assign sec_ones  = so_q;
  assign quarter   = quarter_q;
  assign running   = running_q;
  assign qtr_end   = qtr_end_q;
  assign game_over = game_over_q;

endmodule
